// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial arithmetic cells.
package arith_pkg;

    // Largest operand width supported by serial_sub.
    localparam int unsigned SERIAL_SUB_MAX_WIDTH = 32;

    // Control states of the bit-serial subtractor.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_sub_state_t;

endpackage

// File: rtl/full_sub.sv
// Single-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of one bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: computes a - b LSB-first, one bit per clock.
module serial_sub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > SERIAL_SUB_MAX_WIDTH) begin : g_width_check
        $error("serial_sub: WIDTH must be in 2..%0d", SERIAL_SUB_MAX_WIDTH);
    end

    serial_sub_state_t state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              br_q, br_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              zero_q, zero_d;

    logic              cell_d;
    logic              cell_bout;
    logic [WIDTH-1:0]  res_next;

    full_sub u_full_sub (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Partial result with the newest bit entering from the MSB side.
    assign res_next = (res_q >> 1) | ({cell_d, {(WIDTH-1){1'b0}}});

    // Next-state logic: operand capture, per-bit shift and result publication.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d  = res_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = cell_bout;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    // Last bit: publish the full result on entry to DONE.
                    diff_d  = res_next;
                    bout_d  = cell_bout;
                    zero_d  = (res_next == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    // Status strobes decode directly from the registered state.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        diff = diff_q;
        bout = bout_q;
        zero = zero_q;
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH = 8): vector table, corner sequences, random ops.
module tb_serial_sub;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] ed;
        logic         eb;
        logic         ez;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain modular arithmetic and unsigned comparison.
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned m;
        m = (int'(x) - int'(y) + (1 << W)) % (1 << W);
        return m[W-1:0];
    endfunction

    function automatic logic model_bout(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x < y);
    endfunction

    // One isolated operation from IDLE, called at a negedge.
    task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ed, input logic eb, input logic ez);
        logic [W-1:0] held;
        int cyc, busy_n;
        bit got, overlap, moved;
        held = diff;
        a = ia; b = ib; start = 1'b1;
        cyc = 0; busy_n = 0; got = 0; overlap = 0; moved = 0;
        while (!got && cyc < 3 * W) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy && done) overlap = 1;
            if (busy) busy_n++;
            if (done) got = 1;
            else if (diff !== held) moved = 1;
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(W + 1));
        check({name, " busy_cycles"}, 32'(busy_n), 32'(W));
        check({name, " busy_done_overlap"}, 32'(overlap), 32'd0);
        check({name, " diff_moved_midrun"}, 32'(moved), 32'd0);
        check({name, " diff"}, 32'(diff), 32'(ed));
        check({name, " bout"}, 32'(bout), 32'(eb));
        check({name, " zero"}, 32'(zero), 32'(ez));
        @(negedge clk);
        check({name, " done_one_cycle"}, 32'(done), 32'd0);
        check({name, " diff_hold"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        int cyc, k, guard;
        bit got;
        logic [W-1:0] ra, rb, ed;
        logic [W-1:0] ba[5];
        logic [W-1:0] bb[5];

        vecs[0] = '{8'd5,  8'd3,  8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'd3,  8'd5,  8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset bout", 32'(bout), 32'd0);
        check("reset zero", 32'(zero), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb,
                   vecs[i].ez);
        end

        // Back-to-back: start held high, new operands presented in each DONE cycle.
        ba[0] = 8'd5; bb[0] = 8'd3;
        ba[1] = 8'd3; bb[1] = 8'd5;
        for (int i = 2; i < 5; i++) begin
            ba[i] = W'($urandom); bb[i] = W'($urandom);
        end
        start = 1'b1; a = ba[0]; b = bb[0];
        k = 0; cyc = 0; guard = 0;
        while (k < 5 && guard < 80) begin
            @(negedge clk);
            guard++;
            cyc++;
            if (done) begin
                check($sformatf("b2b%0d latency", k), 32'(cyc), 32'(W + 1));
                check($sformatf("b2b%0d busy_in_done", k), 32'(busy), 32'd0);
                check($sformatf("b2b%0d diff", k), 32'(diff), 32'(model_diff(ba[k], bb[k])));
                check($sformatf("b2b%0d bout", k), 32'(bout), 32'(model_bout(ba[k], bb[k])));
                k++;
                cyc = 0;
                if (k < 5) begin
                    a = ba[k]; b = bb[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        check("b2b results", 32'(k), 32'd5);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Start pulsed in RUN cycle 3 with other operands must be ignored.
        ed = diff;
        a = 8'h10; b = 8'h30; start = 1'b1;
        cyc = 0; got = 0;
        while (!got && cyc < 3 * W) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 3) begin
                start = 1'b1; a = 8'h55; b = 8'h11;
            end
            if (done) got = 1;
            else if (cyc < W + 1) check($sformatf("ign diff_hold c%0d", cyc), 32'(diff), 32'(ed));
        end
        check("ign latency", 32'(cyc), 32'(W + 1));
        check("ign diff", 32'(diff), 32'h00E0);
        check("ign bout", 32'(bout), 32'd1);
        got = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) got = 1;
        end
        check("ign no_second_op", 32'(got), 32'd0);

        // Reset during RUN cycle 4 discards the operation and clears outputs.
        a = 8'h40; b = 8'h01; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst diff", 32'(diff), 32'd0);
        check("rst bout", 32'(bout), 32'd0);
        check("rst zero", 32'(zero), 32'd0);
        got = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) got = 1;
        end
        check("rst no_done", 32'(got), 32'd0);
        run_op("post_rst", 8'd10, 8'd4, 8'h06, 1'b0, 1'b0);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = (i % 7 == 0) ? ra : W'($urandom);
            ed = model_diff(ra, rb);
            run_op($sformatf("rnd%0d", i), ra, rb, ed, model_bout(ra, rb), (ed == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
